// File: rtl/muldiv_unit.sv
// Multiply / multiply-accumulate / restoring-divide unit with a single operation in flight.
// Multiply family completes after MUL_LAT cycles, division after WIDTH+1 cycles (1 on divide-by-zero).
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam logic [6:0] MUL_DONE = 7'(MUL_LAT - 1);
  localparam logic [6:0] MUL_END  = 7'(MUL_LAT);
  localparam logic [6:0] DIV_LAST = 7'(WIDTH - 1);

  state_t     state;
  logic [6:0] cnt;

  function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  // Operand decode and the combinational multiply/accumulate result
  logic                   is_signed;
  logic                   is_div;
  logic                   b_zero;
  logic                   a_neg;
  logic                   b_neg;
  logic [WIDTH-1:0]       a_mag;
  logic [WIDTH-1:0]       b_mag;
  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] acc_full;
  logic signed [2*WIDTH-1:0] mul_res;

  always_comb begin
    is_signed = ~op[0];
    is_div    = (op[2:1] == 2'b01);
    b_zero    = (opb == '0);
    a_neg     = is_signed & opa[WIDTH-1];
    b_neg     = is_signed & opb[WIDTH-1];
    a_mag     = a_neg ? -opa : opa;
    b_mag     = b_neg ? -opb : opb;
    a_ext     = is_signed ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
    b_ext     = is_signed ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
    prod      = a_ext * b_ext;
    acc_full  = {acc_hi, acc_lo};
    if (!op[2]) begin
      mul_res = prod;
    end else if (op[1]) begin
      mul_res = acc_full - prod;
    end else begin
      mul_res = acc_full + prod;
    end
  end

  // Stage p0: operands captured at accept, iterated in place while dividing
  logic signed [2*WIDTH-1:0] mul_res_p0;
  logic [WIDTH-1:0]          rem_p0;
  logic [WIDTH-1:0]          quo_p0;
  logic [WIDTH-1:0]          dvs_p0;
  logic                      neg_q_p0;
  logic                      neg_r_p0;

  logic [WIDTH:0]   shifted;
  logic             take;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  // One restoring step: shift next dividend bit in, subtract divisor if it fits
  always_comb begin
    shifted = {rem_p0, quo_p0[WIDTH-1]};
    take    = (shifted >= {1'b0, dvs_p0});
    rem_nx  = take ? WIDTH'(shifted - {1'b0, dvs_p0}) : shifted[WIDTH-1:0];
    quo_nx  = {quo_p0[WIDTH-2:0], take};
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      mul_res_p0 <= mul_res;
      rem_p0     <= '0;
      quo_p0     <= a_mag;
      dvs_p0     <= b_mag;
      neg_q_p0   <= a_neg ^ b_neg;
      neg_r_p0   <= a_neg;
    end else if (state == DIV) begin
      rem_p0 <= rem_nx;
      quo_p0 <= quo_nx;
    end
  end

  // Control and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi_o        <= '0;
      lo_o        <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            if (is_div) begin
              if (b_zero) begin
                state       <= FIX;
                done        <= 1'b1;
                div_by_zero <= 1'b1;
                hi_o        <= opa;
                lo_o        <= '1;
              end else begin
                state <= DIV;
                cnt   <= '0;
              end
            end else begin
              state <= MUL;
              cnt   <= 7'd1;
              if (MUL_LAT == 1) begin
                done         <= 1'b1;
                {hi_o, lo_o} <= mul_res;
              end
            end
          end
        end
        MUL: begin
          if (cancel || cnt == MUL_END) begin
            state <= IDLE;
          end else begin
            if (cnt == MUL_DONE) begin
              done         <= 1'b1;
              {hi_o, lo_o} <= mul_res_p0;
            end
            cnt <= cnt + 7'd1;
          end
        end
        DIV: begin
          if (cancel) begin
            state <= IDLE;
          end else if (cnt == DIV_LAST) begin
            state <= FIX;
            done  <= 1'b1;
            hi_o  <= sign_fix(rem_nx, neg_r_p0);
            lo_o  <= sign_fix(quo_nx, neg_q_p0);
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        FIX: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32, MUL_LAT=2.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, cancel;
  logic [2:0]  op;
  logic [31:0] opa, opb, acc_hi, acc_lo;
  logic        busy, done, div_by_zero;
  logic [31:0] hi_o, lo_o;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  muldiv_unit #(.WIDTH(32), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .acc_hi(acc_hi), .acc_lo(acc_lo), .cancel(cancel), .busy(busy),
    .done(done), .hi_o(hi_o), .lo_o(lo_o), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour computed with 64-bit arithmetic
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, b, ah, al);
    exp_t r;
    logic signed [63:0] sa, sbv, sq, sr, sp;
    logic [63:0] ua, ub, uq, ur, p, acc, res;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    acc = {ah, al};
    r.dbz = 1'b0;
    if (o == 3'd2 || o == 3'd3) begin
      if (b == 32'h0) begin
        r.hi = a; r.lo = 32'hFFFFFFFF; r.dbz = 1'b1; r.lat = 1;
      end else if (o == 3'd2) begin
        sq = sa / sbv; sr = sa % sbv;
        r.lo = sq[31:0]; r.hi = sr[31:0]; r.lat = 33;
      end else begin
        uq = ua / ub; ur = ua % ub;
        r.lo = uq[31:0]; r.hi = ur[31:0]; r.lat = 33;
      end
    end else begin
      if (o[0]) begin
        p = ua * ub;
      end else begin
        sp = sa * sbv;
        p  = sp;
      end
      if (!o[2])     res = p;
      else if (o[1]) res = acc - p;
      else           res = acc + p;
      r.hi = res[63:32]; r.lo = res[31:0]; r.lat = 2;
    end
    return r;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, b, ah, al);
    op = o; opa = a; opb = b; acc_hi = ah; acc_lo = al;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Leaves the bench in the done cycle; n is that cycle number, or -1 on timeout
  task automatic wait_done(input int limit, output int n);
    n = 1;
    while (done !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    if (done !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; cancel = 1'b0; op = 3'd0; opa = 32'd3; opb = 32'd4;
    step(); step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
    total++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin bad++; $display("FAIL reset_result got=%h_%h want=0_0", hi_o, lo_o); end
    rst = 1'b0; start = 1'b0;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_no_accept got=%b want=0", busy); end
  endtask

  task automatic test_mult();
    exp_t e;
    sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFA, dbz: 1'b0, lat: 2});
    issue(3'd0, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0);
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL mult_c1 got busy=%b done=%b want 1 0", busy, done); end
    step();
    e = sb.pop_front();
    total++; if (done !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL mult_c2 got done=%b busy=%b want 1 1", done, busy); end
    total++; if (hi_o !== e.hi || lo_o !== e.lo) begin bad++; $display("FAIL mult_result got=%h_%h want=%h_%h", hi_o, lo_o, e.hi, e.lo); end
    last_hi = e.hi; last_lo = e.lo;
    step();
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mult_c3 got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_multu_madd();
    exp_t e;
    int n;
    sb.push_back('{hi: 32'hFFFFFFFE, lo: 32'h00000001, dbz: 1'b0, lat: 2});
    sb.push_back('{hi: 32'h1, lo: 32'h0, dbz: 1'b0, lat: 2});
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
    wait_done(10, n);
    e = sb.pop_front();
    total++; if (n != e.lat) begin bad++; $display("FAIL multu_latency got=%0d want=%0d", n, e.lat); end
    total++; if (hi_o !== e.hi || lo_o !== e.lo) begin bad++; $display("FAIL multu_result got=%h_%h want=%h_%h", hi_o, lo_o, e.hi, e.lo); end
    // MADD request raised in the done cycle must wait until cycle 3
    op = 3'd4; opa = 32'd1; opb = 32'd1; acc_hi = 32'h0; acc_lo = 32'hFFFFFFFF; start = 1'b1;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL madd_c3_idle got busy=%b want 0", busy); end
    step();
    start = 1'b0;
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL madd_c4 got busy=%b done=%b want 1 0", busy, done); end
    step();
    e = sb.pop_front();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL madd_c5_done got=%b want 1", done); end
    total++; if (hi_o !== e.hi || lo_o !== e.lo) begin bad++; $display("FAIL madd_result got=%h_%h want=%h_%h", hi_o, lo_o, e.hi, e.lo); end
    last_hi = e.hi; last_lo = e.lo;
    step();
  endtask

  task automatic test_div();
    exp_t e;
    int n;
    sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD, dbz: 1'b0, lat: 33});
    issue(3'd2, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0);
    wait_done(40, n);
    e = sb.pop_front();
    total++; if (n != e.lat) begin bad++; $display("FAIL div_latency got=%0d want=%0d", n, e.lat); end
    total++; if (hi_o !== e.hi || lo_o !== e.lo || div_by_zero !== e.dbz) begin bad++; $display("FAIL div_result got=%h_%h dbz=%b want=%h_%h dbz=%b", hi_o, lo_o, div_by_zero, e.hi, e.lo, e.dbz); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL div_busy_c33 got=%b want 1", busy); end
    step();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL div_c34 got done=%b busy=%b want 0 0", done, busy); end
    sb.push_back('{hi: 32'h0, lo: 32'h80000000, dbz: 1'b0, lat: 33});
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0);
    wait_done(40, n);
    e = sb.pop_front();
    total++; if (n != e.lat) begin bad++; $display("FAIL div_ovf_latency got=%0d want=%0d", n, e.lat); end
    total++; if (hi_o !== e.hi || lo_o !== e.lo || div_by_zero !== e.dbz) begin bad++; $display("FAIL div_ovf_result got=%h_%h dbz=%b want=%h_%h dbz=%b", hi_o, lo_o, div_by_zero, e.hi, e.lo, e.dbz); end
    last_hi = e.hi; last_lo = e.lo;
    step();
  endtask

  task automatic test_div_zero();
    exp_t e;
    int n;
    sb.push_back('{hi: 32'd5, lo: 32'hFFFFFFFF, dbz: 1'b1, lat: 1});
    issue(3'd3, 32'd5, 32'd0, 32'h0, 32'h0);
    wait_done(40, n);
    e = sb.pop_front();
    total++; if (n != e.lat) begin bad++; $display("FAIL dbz_latency got=%0d want=%0d", n, e.lat); end
    total++; if (hi_o !== e.hi || lo_o !== e.lo || div_by_zero !== e.dbz) begin bad++; $display("FAIL dbz_result got=%h_%h dbz=%b want=%h_%h dbz=%b", hi_o, lo_o, div_by_zero, e.hi, e.lo, e.dbz); end
    last_hi = e.hi; last_lo = e.lo;
    step();
    total++; if (div_by_zero !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL dbz_c2 got dbz=%b done=%b busy=%b want 0 0 0", div_by_zero, done, busy); end
  endtask

  task automatic test_cancel_reset();
    exp_t e;
    int n, nd;
    issue(3'd3, 32'd100, 32'd7, 32'h0, 32'h0);
    repeat (9) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_busy got=%b want 0", busy); end
    nd = 0;
    repeat (40) begin if (done === 1'b1) nd++; step(); end
    total++; if (nd != 0) begin bad++; $display("FAIL cancel_no_done got=%0d want=0", nd); end
    total++; if (hi_o !== last_hi || lo_o !== last_lo) begin bad++; $display("FAIL cancel_hold got=%h_%h want=%h_%h", hi_o, lo_o, last_hi, last_lo); end
    issue(3'd3, 32'd100, 32'd7, 32'h0, 32'h0);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (busy !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin bad++; $display("FAIL midop_reset got busy=%b %h_%h want 0 0_0", busy, hi_o, lo_o); end
    nd = 0;
    repeat (40) begin if (done === 1'b1) nd++; step(); end
    total++; if (nd != 0) begin bad++; $display("FAIL midop_reset_no_done got=%0d want=0", nd); end
    last_hi = '0; last_lo = '0;
    sb.push_back(model(3'd3, 32'd100, 32'd7, 32'h0, 32'h0));
    issue(3'd3, 32'd100, 32'd7, 32'h0, 32'h0);
    wait_done(40, n);
    e = sb.pop_front();
    total++; if (n != e.lat || hi_o !== e.hi || lo_o !== e.lo) begin bad++; $display("FAIL divu_100_7 got n=%0d %h_%h want n=%0d %h_%h", n, hi_o, lo_o, e.lat, e.hi, e.lo); end
    last_hi = e.hi; last_lo = e.lo;
    step();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n, nd, nb, first;
    logic [31:0] got_hi, got_lo;
    sb.push_back('{hi: 32'd1, lo: 32'd333, dbz: 1'b0, lat: 33});
    sb.push_back('{hi: 32'd1, lo: 32'd333, dbz: 1'b0, lat: 33});
    op = 3'd3; opa = 32'd1000; opb = 32'd3; start = 1'b1;
    step();
    nd = 0; nb = 0; first = -1; got_hi = '0; got_lo = '0;
    for (int c = 1; c <= 33; c++) begin
      if (busy === 1'b1) nb++;
      if (done === 1'b1) begin nd++; first = c; got_hi = hi_o; got_lo = lo_o; end
      step();
    end
    e = sb.pop_front();
    total++; if (nd != 1 || first != e.lat) begin bad++; $display("FAIL b2b_first_done got count=%0d cycle=%0d want 1 %0d", nd, first, e.lat); end
    total++; if (nb != 33) begin bad++; $display("FAIL b2b_busy_cycles got=%0d want=33", nb); end
    total++; if (got_hi !== e.hi || got_lo !== e.lo) begin bad++; $display("FAIL b2b_first_result got=%h_%h want=%h_%h", got_hi, got_lo, e.hi, e.lo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_c34_idle got=%b want 0", busy); end
    step();
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_reaccept got=%b want 1", busy); end
    wait_done(40, n);
    e = sb.pop_front();
    total++; if (n != e.lat || hi_o !== e.hi || lo_o !== e.lo) begin bad++; $display("FAIL b2b_second got n=%0d %h_%h want n=%0d %h_%h", n, hi_o, lo_o, e.lat, e.hi, e.lo); end
    last_hi = e.hi; last_lo = e.lo;
    step();
  endtask

  task automatic test_cancel_edges();
    exp_t e;
    op = 3'd0; opa = 32'd9; opb = 32'd9; start = 1'b1; cancel = 1'b1;
    step();
    start = 1'b0; cancel = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_over_start got busy=%b want 0", busy); end
    step();
    total++; if (done !== 1'b0 || hi_o !== last_hi) begin bad++; $display("FAIL cancel_over_start_done got done=%b hi=%h want 0 %h", done, hi_o, last_hi); end
    // Cancel one cycle before completion suppresses the result
    issue(3'd1, 32'd11, 32'd13, 32'h0, 32'h0);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    total++; if (done !== 1'b0 || busy !== 1'b0 || lo_o !== last_lo) begin bad++; $display("FAIL cancel_c1 got done=%b busy=%b lo=%h want 0 0 %h", done, busy, lo_o, last_lo); end
    sb.push_back(model(3'd0, 32'd7, 32'hFFFFFFFD, 32'h0, 32'h0));
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 32'h0, 32'h0);
    step();
    cancel = 1'b1;
    e = sb.pop_front();
    total++; if (done !== 1'b1 || hi_o !== e.hi || lo_o !== e.lo) begin bad++; $display("FAIL cancel_at_done got done=%b %h_%h want 1 %h_%h", done, hi_o, lo_o, e.hi, e.lo); end
    step();
    cancel = 1'b0;
    total++; if (busy !== 1'b0 || hi_o !== e.hi || lo_o !== e.lo) begin bad++; $display("FAIL cancel_at_done_hold got busy=%b %h_%h want 0 %h_%h", busy, hi_o, lo_o, e.hi, e.lo); end
    last_hi = e.hi; last_lo = e.lo;
  endtask

  task automatic test_random();
    exp_t e;
    int n;
    logic [2:0]  o;
    logic [31:0] a, b, ah, al;
    for (int i = 0; i < 24; i++) begin
      o  = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 7 == 3) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      if (i % 5 == 1) a = 32'($urandom_range(0, 1000));
      ah = $urandom;
      al = $urandom;
      sb.push_back(model(o, a, b, ah, al));
      issue(o, a, b, ah, al);
      wait_done(40, n);
      e = sb.pop_front();
      total++; if (n != e.lat) begin bad++; $display("FAIL rand%0d_latency op=%0d got=%0d want=%0d", i, o, n, e.lat); end
      total++; if (hi_o !== e.hi || lo_o !== e.lo || div_by_zero !== e.dbz) begin bad++; $display("FAIL rand%0d_result op=%0d a=%h b=%h got=%h_%h dbz=%b want=%h_%h dbz=%b", i, o, a, b, hi_o, lo_o, div_by_zero, e.hi, e.lo, e.dbz); end
      step();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd0;
    opa = '0; opb = '0; acc_hi = '0; acc_lo = '0;
    step();
    test_reset();
    test_mult();
    test_multu_madd();
    test_div();
    test_div_zero();
    test_cancel_reset();
    test_back_to_back();
    test_cancel_edges();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
